mips_clock_sequencer: RTL and testbench

- Debug clock-phase controller for the MIPS system.
- Generates the three overlapping phase enables c0/c1/c2 as a 4-phase rotation of the input clock, gated by a run/halt/single-step state machine and the PLL locked input.
- Lets the debug front end free-run, halt on a machine-cycle boundary, or advance exactly N machine cycles.
- Keeps a wrapping machine-cycle counter for the debug display.

---
 rtl/mips_clock_sequencer_if.sv | 29 ++
 rtl/mips_clock_sequencer.sv | 134 +++++++++++++
 tb/tb_mips_clock_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_clock_sequencer_if.sv
// Command and status bundle between the debug front end and the clock-phase sequencer.
interface mips_clock_sequencer_if #(
    parameter int N_W   = 8,
    parameter int CNT_W = 32
);
    logic             locked;
    logic             run_req;
    logic             halt_req;
    logic             step_req;
    logic [N_W-1:0]   step_n;
    logic             c0;
    logic             c1;
    logic             c2;
    logic [1:0]       phase;
    logic             halted;
    logic             step_done;
    logic             cmd_err;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output locked, run_req, halt_req, step_req, step_n,
        input  c0, c1, c2, phase, halted, step_done, cmd_err, cycle_cnt
    );

    modport slave (
        input  locked, run_req, halt_req, step_req, step_n,
        output c0, c1, c2, phase, halted, step_done, cmd_err, cycle_cnt
    );
endinterface

// File: rtl/mips_clock_sequencer.sv
// Phase-enable generator with run/halt/step control; states: WAIT_LOCK (no clock source),
// HALTED (idle on cycle boundary), RUNNING (free run), STEPPING (run remaining cycles then halt).
module mips_clock_sequencer #(
    parameter int N_W      = 8,
    parameter int CNT_W    = 32,
    parameter bit AUTO_RUN = 1'b0
) (
    input logic                   inclk0,
    input logic                   reset,
    mips_clock_sequencer_if.slave bus
);
    typedef enum logic [1:0] {WAIT_LOCK, HALTED, RUNNING, STEPPING} state_e;

    state_e           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [2:0]       c_q, c_d;
    logic             halted_q, halted_d;
    logic             step_done_q, step_done_d;
    logic             cmd_err_q, cmd_err_d;
    logic             halt_pend_q, halt_pend_d;
    logic [N_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic do_halt, do_step, do_run, active_d;

    function automatic logic [2:0] phase_pattern(input logic [1:0] p);
        case (p)
            2'd0:    return 3'b100;
            2'd1:    return 3'b110;
            2'd2:    return 3'b011;
            default: return 3'b001;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        halt_pend_d = halt_pend_q;
        cycle_cnt_d = cycle_cnt_q;
        step_done_d = 1'b0;
        cmd_err_d   = 1'b0;

        // halt > step > run; losers in the same cycle vanish without an error
        do_halt = bus.halt_req;
        do_step = bus.step_req & ~bus.halt_req;
        do_run  = bus.run_req & ~bus.halt_req & ~bus.step_req;

        if (!bus.locked) begin
            state_d     = WAIT_LOCK;
            phase_d     = 2'd0;
            remaining_d = '0;
            halt_pend_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d = AUTO_RUN ? RUNNING : HALTED;
                    phase_d = 2'd0;
                end
                HALTED: begin
                    phase_d = 2'd0;
                    if (do_step) begin
                        state_d     = STEPPING;
                        remaining_d = (bus.step_n == '0) ? N_W'(1) : bus.step_n;
                    end else if (do_run) begin
                        state_d = RUNNING;
                    end
                end
                RUNNING, STEPPING: begin
                    phase_d = phase_q + 2'd1;
                    if (do_halt)
                        halt_pend_d = 1'b1;
                    if (do_step || (do_run && state_q == STEPPING))
                        cmd_err_d = 1'b1;
                    if (phase_q == 2'd3) begin
                        cycle_cnt_d = cycle_cnt_q + 1'b1;
                        if (halt_pend_q || do_halt) begin
                            state_d     = HALTED;
                            halt_pend_d = 1'b0;
                            remaining_d = '0;
                        end else if (state_q == STEPPING) begin
                            remaining_d = remaining_q - 1'b1;
                            if (remaining_q == N_W'(1)) begin
                                state_d     = HALTED;
                                step_done_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = WAIT_LOCK;
            endcase
        end

        // outputs follow the next state so entering an active state shows p0 on that edge
        active_d = (state_d == RUNNING) || (state_d == STEPPING);
        if (!active_d)
            phase_d = 2'd0;
        c_d      = active_d ? phase_pattern(phase_d) : 3'b000;
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge inclk0) begin
        if (reset) begin
            state_q     <= WAIT_LOCK;
            phase_q     <= 2'd0;
            c_q         <= 3'b000;
            halted_q    <= 1'b0;
            step_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            halt_pend_q <= 1'b0;
            remaining_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            c_q         <= c_d;
            halted_q    <= halted_d;
            step_done_q <= step_done_d;
            cmd_err_q   <= cmd_err_d;
            halt_pend_q <= halt_pend_d;
            remaining_q <= remaining_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.c0        = c_q[2];
    assign bus.c1        = c_q[1];
    assign bus.c2        = c_q[0];
    assign bus.phase     = phase_q;
    assign bus.halted    = halted_q;
    assign bus.step_done = step_done_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.cycle_cnt = cycle_cnt_q;
endmodule

// File: tb/tb_mips_clock_sequencer.sv
// Directed bench: dut_a (AUTO_RUN=0, 32-bit count) for command handling, dut_b (AUTO_RUN=1, 4-bit count) for lock loss and wrap.
module tb_mips_clock_sequencer;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;
    logic [2:0] pat [4];

    always #5 clk = ~clk;

    mips_clock_sequencer_if #(.N_W(8), .CNT_W(32)) ifa ();
    mips_clock_sequencer_if #(.N_W(8), .CNT_W(4))  ifb ();

    mips_clock_sequencer #(.N_W(8), .CNT_W(32), .AUTO_RUN(1'b0)) dut_a (
        .inclk0 (clk),
        .reset  (rst_a),
        .bus    (ifa.slave)
    );

    mips_clock_sequencer #(.N_W(8), .CNT_W(4), .AUTO_RUN(1'b1)) dut_b (
        .inclk0 (clk),
        .reset  (rst_b),
        .bus    (ifb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] cva();
        return {ifa.c0, ifa.c1, ifa.c2, ifa.phase};
    endfunction

    function automatic logic [4:0] cvb();
        return {ifb.c0, ifb.c1, ifb.c2, ifb.phase};
    endfunction

    initial begin
        pat[0] = 3'b100; pat[1] = 3'b110; pat[2] = 3'b011; pat[3] = 3'b001;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.locked = 1'b0; ifa.run_req = 1'b0; ifa.halt_req = 1'b0; ifa.step_req = 1'b0; ifa.step_n = 8'd0;
        ifb.locked = 1'b0; ifb.run_req = 1'b0; ifb.halt_req = 1'b0; ifb.step_req = 1'b0; ifb.step_n = 8'd0;
        tick(2);

        chk("rst_halted",    ifa.halted, 0);
        chk("rst_cvec",      cva(), 0);
        chk("rst_cnt",       ifa.cycle_cnt, 0);
        chk("rst_pulses",    {ifa.step_done, ifa.cmd_err}, 0);
        chk("rst_b_cvec",    cvb(), 0);

        rst_a = 1'b0; rst_b = 1'b0; ifa.locked = 1'b1;
        tick();
        chk("lock_halted",   ifa.halted, 1);
        chk("lock_cvec",     cva(), 0);
        chk("lock_cnt",      ifa.cycle_cnt, 0);

        // three-cycle step: 12 active phases then halt
        ifa.step_n = 8'd3; ifa.step_req = 1'b1;
        tick();
        ifa.step_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            chk("step3_cvec", cva(), {pat[i % 4], 2'(i % 4)});
            chk("step3_busy", {ifa.halted, ifa.step_done}, 0);
        end
        tick();
        chk("step3_end_cvec", cva(), 0);
        chk("step3_end_halt", ifa.halted, 1);
        chk("step3_done",     ifa.step_done, 1);
        chk("step3_cnt",      ifa.cycle_cnt, 3);
        tick();
        chk("step3_done_clr", ifa.step_done, 0);

        // run, halt during p1 of the 5th cycle: count goes 3 -> 8
        ifa.run_req = 1'b1;
        tick();
        ifa.run_req = 1'b0;
        chk("run_p0", cva(), {3'b100, 2'd0});
        tick(17);
        chk("run_c5_p1", cva(), {3'b110, 2'd1});
        chk("run_c5_cnt", ifa.cycle_cnt, 7);
        ifa.halt_req = 1'b1;
        tick();
        ifa.halt_req = 1'b0;
        chk("halt_p2", cva(), {3'b011, 2'd2});
        tick();
        chk("halt_p3", cva(), {3'b001, 2'd3});
        tick();
        chk("halt_cvec", cva(), 0);
        chk("halt_halted", ifa.halted, 1);
        chk("halt_cnt", ifa.cycle_cnt, 8);

        // simultaneous commands in HALTED: halt wins silently
        ifa.halt_req = 1'b1; ifa.run_req = 1'b1;
        tick();
        ifa.halt_req = 1'b0; ifa.run_req = 1'b0;
        chk("hr_halted", {ifa.halted, ifa.cmd_err}, 2'b10);
        chk("hr_cvec", cva(), 0);
        ifa.halt_req = 1'b1; ifa.step_req = 1'b1; ifa.step_n = 8'd2;
        tick();
        ifa.halt_req = 1'b0; ifa.step_req = 1'b0;
        chk("hs_halted", {ifa.halted, ifa.cmd_err}, 2'b10);
        chk("hs_cvec", cva(), 0);

        // step_req while running: error pulse, rotation undisturbed
        ifa.run_req = 1'b1;
        tick();
        ifa.run_req = 1'b0;
        tick();
        chk("rs_p1", cva(), {3'b110, 2'd1});
        ifa.step_req = 1'b1; ifa.step_n = 8'd5;
        tick();
        ifa.step_req = 1'b0;
        chk("rs_p2", cva(), {3'b011, 2'd2});
        chk("rs_err", ifa.cmd_err, 1);
        tick();
        chk("rs_p3", cva(), {3'b001, 2'd3});
        chk("rs_err_clr", ifa.cmd_err, 0);
        tick();
        chk("rs_p0", cva(), {3'b100, 2'd0});
        chk("rs_running", ifa.halted, 0);
        chk("rs_cnt", ifa.cycle_cnt, 9);
        ifa.halt_req = 1'b1;
        tick();
        ifa.halt_req = 1'b0;
        tick(3);
        chk("rs_halt", {ifa.halted, cva()}, {1'b1, 5'd0});
        chk("rs_halt_cnt", ifa.cycle_cnt, 10);

        // step_n = 0 behaves as one cycle
        ifa.step_n = 8'd0; ifa.step_req = 1'b1;
        tick();
        ifa.step_req = 1'b0;
        chk("s0_p0", cva(), {3'b100, 2'd0});
        tick(3);
        chk("s0_p3", {cva(), ifa.step_done}, {3'b001, 2'd3, 1'b0});
        tick();
        chk("s0_end", {ifa.halted, ifa.step_done, cva()}, {2'b11, 5'd0});
        chk("s0_cnt", ifa.cycle_cnt, 11);

        // halt during a step sequence: stop after current cycle, no step_done
        ifa.step_n = 8'd4; ifa.step_req = 1'b1;
        tick();
        ifa.step_req = 1'b0; ifa.halt_req = 1'b1;
        tick();
        ifa.halt_req = 1'b0;
        tick(3);
        chk("sh_end", {ifa.halted, ifa.step_done, cva()}, {2'b10, 5'd0});
        chk("sh_cnt", ifa.cycle_cnt, 12);
        tick();
        chk("sh_stay", {ifa.halted, cva()}, {1'b1, 5'd0});

        // reset mid-cycle clears the counter too
        ifa.run_req = 1'b1;
        tick();
        ifa.run_req = 1'b0;
        tick();
        rst_a = 1'b1;
        tick();
        chk("mr_state", {ifa.halted, cva()}, 0);
        chk("mr_cnt", ifa.cycle_cnt, 0);
        rst_a = 1'b0;
        tick();
        chk("mr_relock", ifa.halted, 1);

        // dut_b: auto-run on lock, 17 cycles wrap a 4-bit counter
        ifb.locked = 1'b1;
        tick();
        chk("ar_p0", cvb(), {3'b100, 2'd0});
        chk("ar_halted", ifb.halted, 0);
        tick(60);
        chk("wrap_15", ifb.cycle_cnt, 15);
        tick(4);
        chk("wrap_0", ifb.cycle_cnt, 0);
        tick(4);
        chk("wrap_1", ifb.cycle_cnt, 1);
        chk("wrap_p0", cvb(), {3'b100, 2'd0});

        // lock lost during p2: partial cycle dropped, count kept
        tick(2);
        chk("ll_p2", cvb(), {3'b011, 2'd2});
        ifb.locked = 1'b0;
        tick();
        chk("ll_cvec", {ifb.halted, cvb()}, 0);
        chk("ll_cnt", ifb.cycle_cnt, 1);
        tick();
        chk("ll_stay", cvb(), 0);
        ifb.locked = 1'b1;
        tick();
        chk("rl_p0", cvb(), {3'b100, 2'd0});
        chk("rl_cnt", ifb.cycle_cnt, 1);
        tick(4);
        chk("rl_cnt_next", ifb.cycle_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
